// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates entries at dispatch, captures CDB results,
// commits the head in program order and raises a one-cycle flush on next-pc mispredict.
module reorder_buffer #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned RoB_WIDTH    = 3,
    parameter int unsigned EX_RoB_WIDTH = 4
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    DPRB_en,
    input  logic [1:0]              DPRB_type,
    input  logic [4:0]              DPRB_rd,
    input  logic [ADDR_WIDTH-1:0]   DPRB_pred_pc,
    output logic                    RBDP_full,
    output logic [RoB_WIDTH-1:0]    RBDP_tail,
    input  logic [EX_RoB_WIDTH-1:0] DPRB_Qj,
    input  logic [EX_RoB_WIDTH-1:0] DPRB_Qk,
    output logic                    RBDP_Vj_rdy,
    output logic                    RBDP_Vk_rdy,
    output logic [31:0]             RBDP_Vj,
    output logic [31:0]             RBDP_Vk,
    input  logic                    CDBRB_RS_en,
    input  logic [RoB_WIDTH-1:0]    CDBRB_RS_RoB_index,
    input  logic [31:0]             CDBRB_RS_value,
    input  logic [ADDR_WIDTH-1:0]   CDBRB_RS_next_pc,
    input  logic                    CDBRB_LSB_en,
    input  logic [RoB_WIDTH-1:0]    CDBRB_LSB_RoB_index,
    input  logic [31:0]             CDBRB_LSB_value,
    output logic                    RBRF_en,
    output logic [4:0]              RBRF_rd,
    output logic [31:0]             RBRF_value,
    output logic [RoB_WIDTH-1:0]    RBRF_RoB_index,
    output logic                    RBLSB_commit_en,
    output logic [RoB_WIDTH-1:0]    RBLSB_RoB_index,
    output logic                    RoBRS_pre_judge,
    output logic                    RBIF_en,
    output logic [ADDR_WIDTH-1:0]   RBIF_pc
);
    localparam int unsigned RoB_SIZE = 1 << RoB_WIDTH;
    localparam int unsigned CNT_W    = RoB_WIDTH + 1;
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {(EX_RoB_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        T_REG   = 2'd0,
        T_BR    = 2'd1,
        T_JUMP  = 2'd2,
        T_STORE = 2'd3
    } rob_type_e;

    logic [RoB_SIZE-1:0]   busy;
    logic [RoB_SIZE-1:0]   ready;
    rob_type_e             ent_type    [RoB_SIZE];
    logic [4:0]            ent_rd      [RoB_SIZE];
    logic [31:0]           ent_value   [RoB_SIZE];
    logic [ADDR_WIDTH-1:0] ent_pred_pc [RoB_SIZE];
    logic [ADDR_WIDTH-1:0] ent_real_pc [RoB_SIZE];

    logic [RoB_WIDTH-1:0] head;
    logic [RoB_WIDTH-1:0] tail;
    logic [CNT_W-1:0]     count;

    logic      full_c;
    logic      alloc_c;
    logic      commit_c;
    logic      mispredict_c;
    logic      rs_cap_c;
    logic      lsb_cap_c;
    rob_type_e head_type_c;

    logic [RoB_WIDTH-1:0] qj_idx;
    logic [RoB_WIDTH-1:0] qk_idx;

    assign full_c      = (count == CNT_W'(RoB_SIZE));
    assign RBDP_full   = full_c;
    assign RBDP_tail   = tail;
    assign head_type_c = ent_type[head];

    // Nothing is accepted while the flush cycle is in progress.
    assign alloc_c      = DPRB_en && !full_c && RoBRS_pre_judge;
    assign commit_c     = busy[head] && ready[head] && RoBRS_pre_judge;
    assign mispredict_c = commit_c && ((head_type_c == T_BR) || (head_type_c == T_JUMP))
                          && (ent_real_pc[head] != ent_pred_pc[head]);
    assign rs_cap_c     = CDBRB_RS_en && RoBRS_pre_judge && busy[CDBRB_RS_RoB_index];
    assign lsb_cap_c    = CDBRB_LSB_en && RoBRS_pre_judge && busy[CDBRB_LSB_RoB_index];

    assign qj_idx = DPRB_Qj[RoB_WIDTH-1:0];
    assign qk_idx = DPRB_Qk[RoB_WIDTH-1:0];

    // Operand lookup with same-cycle CDB forwarding; RS port wins over LSB.
    always_comb begin
        RBDP_Vj_rdy = 1'b0;
        RBDP_Vj     = ent_value[qj_idx];
        if (DPRB_Qj != NON_DEP) begin
            if (CDBRB_RS_en && (CDBRB_RS_RoB_index == qj_idx)) begin
                RBDP_Vj_rdy = 1'b1;
                RBDP_Vj     = CDBRB_RS_value;
            end else if (CDBRB_LSB_en && (CDBRB_LSB_RoB_index == qj_idx)) begin
                RBDP_Vj_rdy = 1'b1;
                RBDP_Vj     = CDBRB_LSB_value;
            end else begin
                RBDP_Vj_rdy = busy[qj_idx] && ready[qj_idx];
            end
        end
    end

    always_comb begin
        RBDP_Vk_rdy = 1'b0;
        RBDP_Vk     = ent_value[qk_idx];
        if (DPRB_Qk != NON_DEP) begin
            if (CDBRB_RS_en && (CDBRB_RS_RoB_index == qk_idx)) begin
                RBDP_Vk_rdy = 1'b1;
                RBDP_Vk     = CDBRB_RS_value;
            end else if (CDBRB_LSB_en && (CDBRB_LSB_RoB_index == qk_idx)) begin
                RBDP_Vk_rdy = 1'b1;
                RBDP_Vk     = CDBRB_LSB_value;
            end else begin
                RBDP_Vk_rdy = busy[qk_idx] && ready[qk_idx];
            end
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst) begin
            busy            <= '0;
            ready           <= '0;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            RBRF_en         <= 1'b0;
            RBRF_rd         <= '0;
            RBRF_value      <= '0;
            RBRF_RoB_index  <= '0;
            RBLSB_commit_en <= 1'b0;
            RBLSB_RoB_index <= '0;
            RoBRS_pre_judge <= 1'b1;
            RBIF_en         <= 1'b0;
            RBIF_pc         <= '0;
        end else if (Sys_rdy) begin
            RBRF_en         <= 1'b0;
            RBLSB_commit_en <= 1'b0;
            RBIF_en         <= 1'b0;
            RoBRS_pre_judge <= 1'b1;

            if (commit_c) begin
                busy[head] <= 1'b0;
                head       <= head + RoB_WIDTH'(1);
                if ((head_type_c == T_REG) || (head_type_c == T_JUMP)) begin
                    RBRF_en        <= 1'b1;
                    RBRF_rd        <= ent_rd[head];
                    RBRF_value     <= ent_value[head];
                    RBRF_RoB_index <= head;
                end
                if (head_type_c == T_STORE) begin
                    RBLSB_commit_en <= 1'b1;
                    RBLSB_RoB_index <= head;
                end
            end

            if (rs_cap_c) begin
                ready[CDBRB_RS_RoB_index]       <= 1'b1;
                ent_value[CDBRB_RS_RoB_index]   <= CDBRB_RS_value;
                ent_real_pc[CDBRB_RS_RoB_index] <= CDBRB_RS_next_pc;
            end
            if (lsb_cap_c) begin
                ready[CDBRB_LSB_RoB_index]     <= 1'b1;
                ent_value[CDBRB_LSB_RoB_index] <= CDBRB_LSB_value;
            end

            if (alloc_c) begin
                busy[tail]        <= 1'b1;
                ready[tail]       <= 1'b0;
                ent_type[tail]    <= rob_type_e'(DPRB_type);
                ent_rd[tail]      <= DPRB_rd;
                ent_pred_pc[tail] <= DPRB_pred_pc;
                tail              <= tail + RoB_WIDTH'(1);
            end

            count <= count + CNT_W'(alloc_c) - CNT_W'(commit_c);

            // Mispredict squashes every entry, including any allocation on this edge.
            if (mispredict_c) begin
                busy            <= '0;
                ready           <= '0;
                head            <= '0;
                tail            <= '0;
                count           <= '0;
                RoBRS_pre_judge <= 1'b0;
                RBIF_en         <= 1'b1;
                RBIF_pc         <= ent_real_pc[head];
            end
        end
    end

endmodule
